// File: rtl/len_counter.sv
// len_counter: per-channel sound length counter.
// A trigger loads (2^WIDTH - lenLoad) length steps and turns the channel on.
// Each enabled length step counts down. The channel turns off when the count reaches zero.
// Optional build macro LEN_COUNTER_ZERO_RELOAD_EN: a trigger reloads the count
// only when the count has already expired. A trigger while counting only
// re-asserts chanEnable.
module len_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lenLoad,
  input  logic             trigger,
  input  logic             lenEnable,
  output logic             chanEnable
);

  // One extra bit so that a load of 0 can represent the full 2^WIDTH steps.
  localparam logic [WIDTH:0] FULL_LEN = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] ZERO     = '0;

  logic [WIDTH:0] count_q, count_d;
  logic           chan_en_q, chan_en_d;
  logic [WIDTH:0] load_val;
  logic           do_load;

  assign load_val = FULL_LEN - {1'b0, lenLoad};

`ifdef LEN_COUNTER_ZERO_RELOAD_EN
  // A trigger reloads only when the count has already expired.
  // A trigger that arrives while counting keeps the running count.
  assign do_load = (count_q == ZERO);
`else
  // Every trigger restarts the count from the load value.
  assign do_load = 1'b1;
`endif

  // Next-state: a trigger has priority. Otherwise count down while enabled and saturate at zero.
  always_comb begin
    count_d   = count_q;
    chan_en_d = chan_en_q;
    if (trigger) begin
      if (do_load) begin
        count_d = load_val;
      end
      chan_en_d = 1'b1;
    end else if (lenEnable) begin
      if (count_q != ZERO) begin
        count_d   = count_q - ONE;
        chan_en_d = (count_q != ONE);
      end else begin
        chan_en_d = 1'b0;
      end
    end
  end

  // State registers. Asynchronous reset clears the count and disables the channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= ZERO;
      chan_en_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      chan_en_q <= chan_en_d;
    end
  end

  assign chanEnable = chan_en_q;

endmodule

// File: tb/tb_len_counter.sv
// Self-checking bench for len_counter (WIDTH=6) with a behavioural length model.
module tb_len_counter;
  localparam int WIDTH = 6;
  localparam int FULL  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] lenLoad = '0;
  logic             trigger = 1'b0;
  logic             lenEnable = 1'b0;
  logic             chanEnable;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining length steps and channel state.
  int remaining = 0;
  bit on_ref = 1'b0;

  len_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .lenLoad(lenLoad),
    .trigger(trigger),
    .lenEnable(lenEnable),
    .chanEnable(chanEnable)
  );

  always #5 clk = ~clk;

  // Apply one length step to the model using the inputs presented at the edge.
  function automatic void model_step();
    bit reload;
    reload = 1'b1;
`ifdef LEN_COUNTER_ZERO_RELOAD_EN
    reload = (remaining == 0);
`endif
    if (trigger) begin
      if (reload) remaining = FULL - int'(lenLoad);
      on_ref = 1'b1;
    end else if (lenEnable) begin
      if (remaining > 0) remaining = remaining - 1;
      on_ref = (remaining != 0);
    end
  endfunction

  // Advance one clock. Outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (chanEnable !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: chanEnable=%b expected 0", chanEnable);
    end
    @(negedge clk);
    reset = 1'b0;
    // Build a running count of 5, then hold it.
    lenLoad = 6'(FULL - 5); trigger = 1'b1; lenEnable = 1'b0;
    tick();
    trigger = 1'b0;
    tick();
    checks++;
    if (chanEnable !== 1'b1) begin
      errors++;
      $display("FAIL reset_precond: chanEnable=%b expected 1", chanEnable);
    end
    // Pulse reset between clock edges. The output must clear at once.
    #2 reset = 1'b1;
    remaining = 0; on_ref = 1'b0;
    #1;
    checks++;
    if (chanEnable !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: chanEnable=%b expected 0", chanEnable);
    end
    #2 reset = 1'b0;
    lenEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (chanEnable !== 1'b0 || chanEnable !== on_ref) begin
        errors++;
        $display("FAIL reset_after_edge%0d: chanEnable=%b expected 0", i, chanEnable);
      end
    end
  endtask

  task automatic test_basic();
    bit exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lenLoad = 6'd61; lenEnable = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (chanEnable !== exp_seq[i] || chanEnable !== on_ref) begin
        errors++;
        $display("FAIL basic_step%0d: chanEnable=%b expected %b", i, chanEnable, exp_seq[i]);
      end
    end
  endtask

  task automatic test_full_length();
    int high_steps;
    lenLoad = '0; lenEnable = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    high_steps = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (chanEnable === 1'b1) high_steps++;
      if (chanEnable !== on_ref) begin
        checks++;
        errors++;
        $display("FAIL full_len_step%0d: chanEnable=%b expected %b", i, chanEnable, on_ref);
      end
    end
    checks++;
    if (high_steps !== FULL - 1) begin
      errors++;
      $display("FAIL full_len_count: high steps after trigger=%0d expected %0d", high_steps, FULL - 1);
    end
  endtask

  task automatic test_hold();
    int drop_step;
    lenLoad = 6'd60; lenEnable = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick(); tick();
    lenEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (chanEnable !== 1'b1 || on_ref !== 1'b1) begin
        errors++;
        $display("FAIL hold_edge%0d: chanEnable=%b expected 1", i, chanEnable);
      end
    end
    lenEnable = 1'b1;
    drop_step = 0;
    for (int i = 1; i <= 5 && drop_step == 0; i++) begin
      tick();
      if (chanEnable === 1'b0) drop_step = i;
    end
    checks++;
    if (drop_step !== 2) begin
      errors++;
      $display("FAIL hold_resume: dropped after %0d enabled steps expected 2", drop_step);
    end
  endtask

  task automatic test_retrigger();
    int drop_step, exp_drop;
`ifdef LEN_COUNTER_ZERO_RELOAD_EN
    exp_drop = 1;
`else
    exp_drop = 8;
`endif
    lenLoad = 6'd62; lenEnable = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    lenLoad = 6'd56; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checks++;
    if (chanEnable !== 1'b1) begin
      errors++;
      $display("FAIL retrig_edge: chanEnable=%b expected 1", chanEnable);
    end
    drop_step = 0;
    for (int i = 1; i <= 12 && drop_step == 0; i++) begin
      tick();
      if (chanEnable === 1'b0) drop_step = i;
    end
    checks++;
    if (drop_step !== exp_drop) begin
      errors++;
      $display("FAIL retrig_drop: dropped after %0d steps expected %0d", drop_step, exp_drop);
    end
  endtask

  task automatic test_expired_enable();
    lenLoad = 6'd63; lenEnable = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick(); tick();
    lenEnable = 1'b0; tick();
    lenEnable = 1'b1; tick(); tick();
    checks++;
    if (chanEnable !== 1'b0) begin
      errors++;
      $display("FAIL expired_toggle: chanEnable=%b expected 0", chanEnable);
    end
    trigger = 1'b1; lenLoad = 6'd10;
    tick();
    trigger = 1'b0;
    checks++;
    if (chanEnable !== 1'b1) begin
      errors++;
      $display("FAIL expired_retrigger: chanEnable=%b expected 1", chanEnable);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      trigger   = ($urandom_range(0, 15) == 0);
      lenEnable = ($urandom_range(0, 3) != 0);
      lenLoad   = 6'($urandom_range(0, FULL - 1));
      if ($urandom_range(0, 3) == 0) lenLoad = 6'($urandom_range(FULL - 4, FULL - 1));
      tick();
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        remaining = 0; on_ref = 1'b0;
        #2 reset = 1'b0;
      end
      checks++;
      if (chanEnable !== on_ref) begin
        errors++;
        $display("FAIL random_cycle%0d: chanEnable=%b expected %b", i, chanEnable, on_ref);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_length();
    test_hold();
    test_retrigger();
    test_expired_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
